// File: rtl/vga_sync_gen_if.sv
// ---------------------------------------------------------------------------
// vga_sync_gen_if
//   Output bundle of the VGA timing generator.
//   master : driven by vga_sync_gen (sync, blanking, coordinates, strobes)
//   slave  : consumed by the downstream pixel/colour path
//   Macro VGA_TEST_PATTERN_EN adds the 4-bit red/green/blue test-bar outputs.
// ---------------------------------------------------------------------------
interface vga_sync_gen_if #(
    parameter int unsigned CNT_W = 10
);
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;
    logic             line_start;
    logic             frame_start;
`ifdef VGA_TEST_PATTERN_EN
    logic [3:0]       red;
    logic [3:0]       green;
    logic [3:0]       blue;
`endif

`ifdef VGA_TEST_PATTERN_EN
    modport master (output hsync, vsync, video_on, pixel_x, pixel_y,
                           line_start, frame_start, red, green, blue);
    modport slave  (input  hsync, vsync, video_on, pixel_x, pixel_y,
                           line_start, frame_start, red, green, blue);
`else
    modport master (output hsync, vsync, video_on, pixel_x, pixel_y,
                           line_start, frame_start);
    modport slave  (input  hsync, vsync, video_on, pixel_x, pixel_y,
                           line_start, frame_start);
`endif
endinterface

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//   VGA 640x480@60 Hz timing generator on the 25 MHz pixel clock.
//   Ports:
//     clk_25  : pixel clock, all logic on the rising edge
//     reset_n : asynchronous active-low reset
//     vga     : vga_sync_gen_if.master -- hsync/vsync (active low), video_on,
//               pixel_x/pixel_y (0 outside the visible area), line_start and
//               frame_start strobes.
//   All outputs are registered decodes of the counter position held before
//   the edge (one cycle latency).
//   Optional macro VGA_TEST_PATTERN_EN: adds 8 vertical colour bars, 80 pixels
//   wide, on vga.red/green/blue.
// ---------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned CNT_W     = 10
) (
    input  logic           clk_25,
    input  logic           reset_n,
    vga_sync_gen_if.master vga
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Thresholds pre-sized to the counter width so every compare is unsigned
    // and width-matched.
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic [CNT_W-1:0] pixel_x_q, pixel_x_d;
    logic [CNT_W-1:0] pixel_y_q, pixel_y_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             h_wrap, v_wrap, visible;
`ifdef VGA_TEST_PATTERN_EN
    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(80);
    logic [2:0] bar_idx;
    logic [3:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
`endif

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        v_wrap  = (v_cnt_q == V_LAST);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
        end

        // Decodes of the current position; registered below.
        visible       = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
        hsync_d       = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
        vsync_d       = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
        video_on_d    = visible;
        pixel_x_d     = visible ? h_cnt_q : '0;
        pixel_y_d     = visible ? v_cnt_q : '0;
        line_start_d  = (h_cnt_q == '0);
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);

`ifdef VGA_TEST_PATTERN_EN
        // Only meaningful while visible (h < 640 -> index 0..7).
        bar_idx = 3'(h_cnt_q / BAR_W);
        red_d   = (visible && bar_idx[2]) ? 4'hF : 4'h0;
        green_d = (visible && bar_idx[1]) ? 4'hF : 4'h0;
        blue_d  = (visible && bar_idx[0]) ? 4'hF : 4'h0;
`endif
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
            red_q         <= 4'h0;
            green_q       <= 4'h0;
            blue_q        <= 4'h0;
`endif
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
`ifdef VGA_TEST_PATTERN_EN
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
`endif
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.pixel_x     = pixel_x_q;
    assign vga.pixel_y     = pixel_y_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
`ifdef VGA_TEST_PATTERN_EN
    assign vga.red         = red_q;
    assign vga.green       = green_q;
    assign vga.blue        = blue_q;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//   Two instances share clock and reset: dut_a uses the real 640x480 timing
//   (line-level behaviour), dut_b uses a shrunken timing so whole frames fit
//   in a short run. A position-based reference model predicts every output
//   after each edge; run-length totals are checked against closed-form counts.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;
    // Small timing for dut_b: 17 x 12 = 204 cycles per frame.
    localparam int BH_V = 10, BH_F = 2, BH_S = 3, BH_B = 2;
    localparam int BV_V = 6,  BV_F = 1, BV_S = 2, BV_B = 3;
    localparam int B_HT = BH_V + BH_F + BH_S + BH_B;
    localparam int B_VT = BV_V + BV_F + BV_S + BV_B;

    logic clk_25 = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_25 = ~clk_25;

    vga_sync_gen_if #(.CNT_W(10)) if_a ();
    vga_sync_gen_if #(.CNT_W(10)) if_b ();

    vga_sync_gen dut_a (.clk_25(clk_25), .reset_n(reset_n), .vga(if_a));
    vga_sync_gen #(
        .H_VISIBLE(BH_V), .H_FRONT(BH_F), .H_SYNC(BH_S), .H_BACK(BH_B),
        .V_VISIBLE(BV_V), .V_FRONT(BV_F), .V_SYNC(BV_S), .V_BACK(BV_B),
        .CNT_W(10)
    ) dut_b (.clk_25(clk_25), .reset_n(reset_n), .vga(if_b));

    typedef struct {
        logic       hs, vs, von, ls, fs;
        int         px, py;
        logic [3:0] r, g, b;
    } exp_t;

    int    vectors = 0;
    int    miscompares = 0;
    longint k = 0;           // rising edges since reset release
    int    hs_low_a, ls_a, fs_b, vs_low_b, von_b, ls_b;

    // Expected outputs after k edges: position k-1 laid out row-major.
    function automatic exp_t model(longint kk, int hv, int hf, int hs, int hb,
                                   int vv, int vf, int vs, int vb);
        exp_t e;
        longint p;
        int ht, vt, h, v, bar;
        e = '{hs: 1'b1, vs: 1'b1, von: 1'b0, ls: 1'b0, fs: 1'b0,
              px: 0, py: 0, r: 4'h0, g: 4'h0, b: 4'h0};
        if (kk == 0) return e;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        p  = kk - 1;
        h  = int'(p % ht);
        v  = int'((p / ht) % vt);
        e.hs  = !(h >= hv + hf && h < hv + hf + hs);
        e.vs  = !(v >= vv + vf && v < vv + vf + vs);
        e.von = (h < hv) && (v < vv);
        e.ls  = (h == 0);
        e.fs  = (h == 0) && (v == 0);
        if (e.von) begin
            e.px = h;
            e.py = v;
            bar  = h / 80;
            e.r  = (bar >= 4)        ? 4'hF : 4'h0;
            e.g  = ((bar / 2) % 2)   ? 4'hF : 4'h0;
            e.b  = (bar % 2)         ? 4'hF : 4'h0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        exp_t ea, eb;
        ea = model(k, 640, 16, 96, 48, 480, 10, 2, 33);
        eb = model(k, BH_V, BH_F, BH_S, BH_B, BV_V, BV_F, BV_S, BV_B);
        chk("a.hsync",       int'(if_a.hsync),       int'(ea.hs));
        chk("a.vsync",       int'(if_a.vsync),       int'(ea.vs));
        chk("a.video_on",    int'(if_a.video_on),    int'(ea.von));
        chk("a.pixel_x",     int'(if_a.pixel_x),     ea.px);
        chk("a.pixel_y",     int'(if_a.pixel_y),     ea.py);
        chk("a.line_start",  int'(if_a.line_start),  int'(ea.ls));
        chk("a.frame_start", int'(if_a.frame_start), int'(ea.fs));
        chk("b.hsync",       int'(if_b.hsync),       int'(eb.hs));
        chk("b.vsync",       int'(if_b.vsync),       int'(eb.vs));
        chk("b.video_on",    int'(if_b.video_on),    int'(eb.von));
        chk("b.pixel_x",     int'(if_b.pixel_x),     eb.px);
        chk("b.pixel_y",     int'(if_b.pixel_y),     eb.py);
        chk("b.line_start",  int'(if_b.line_start),  int'(eb.ls));
        chk("b.frame_start", int'(if_b.frame_start), int'(eb.fs));
`ifdef VGA_TEST_PATTERN_EN
        chk("a.red",   int'(if_a.red),   int'(ea.r));
        chk("a.green", int'(if_a.green), int'(ea.g));
        chk("a.blue",  int'(if_a.blue),  int'(ea.b));
        chk("b.red",   int'(if_b.red),   int'(eb.r));
        chk("b.green", int'(if_b.green), int'(eb.g));
        chk("b.blue",  int'(if_b.blue),  int'(eb.b));
`endif
    endtask

    task automatic clear_totals();
        hs_low_a = 0; ls_a = 0; fs_b = 0; vs_low_b = 0; von_b = 0; ls_b = 0;
    endtask

    // Advance n edges, checking every output mid-cycle and keeping totals.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk_25);
            if (reset_n) k++;
            @(negedge clk_25);
            check_all();
            if (!if_a.hsync)      hs_low_a++;
            if (if_a.line_start)  ls_a++;
            if (if_b.frame_start) fs_b++;
            if (!if_b.vsync)      vs_low_b++;
            if (if_b.video_on)    von_b++;
            if (if_b.line_start)  ls_b++;
        end
    endtask

    // Assert reset between edges and check outputs respond before the next
    // edge, hold for a few cycles, then release between edges.
    task automatic async_reset(input int hold);
        @(negedge clk_25);
        #2 reset_n = 1'b0;
        k = 0;
        #1 check_all();
        run(hold);
        @(negedge clk_25);
        #2 reset_n = 1'b1;
        clear_totals();
    endtask

    initial begin
        clear_totals();
        // Held in reset from time 0.
        run(3);
        @(negedge clk_25);
        #2 reset_n = 1'b1;
        clear_totals();

        // Four small frames == a bit more than one full line of dut_a.
        run(4 * B_HT * B_VT);
        chk("a.hsync_low_line0", hs_low_a, 96);
        chk("a.line_starts",     ls_a, 2);
        chk("b.frame_starts",    fs_b, 4);
        chk("b.vsync_low",       vs_low_b, 4 * BV_S * B_HT);
        chk("b.video_on_cycles", von_b, 4 * BV_V * BH_V);
        chk("b.line_starts",     ls_b, 4 * B_VT);

        // Mid-line reset on dut_a at h=700, v=2 (inside hsync pulse).
        async_reset(2);
        run(2 * 800 + 700 + 1);
        chk("a.hsync_pre_reset", int'(if_a.hsync), 0);
        async_reset(1);
        run(1);
        chk("a.frame_start_post", int'(if_a.frame_start), 1);

        // Randomised reset points and run lengths.
        repeat (6) begin
            async_reset(int'($urandom_range(1, 3)));
            run(int'($urandom_range(100, 2500)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
